// File: rtl/tile_transpose_pp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tile_transpose_pp_pkg
// Brief   : Shared defaults, tile mode encoding and lane slicing helper.
// Revision: 1.0
// ============================================================================
package tile_transpose_pp_pkg;

    localparam int c_T_DEFAULT      = 16;
    localparam int c_DW_DEFAULT     = 8;
    localparam int c_LOG2_T_DEFAULT = 4;

    typedef enum logic {
        MODE_TRANSPOSE = 1'b0,
        MODE_BYPASS    = 1'b1
    } mode_e;

    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_bank.sv
`default_nettype none
// ============================================================================
// Module  : tile_bank
// Brief   : T x T x DW tile store, row write port, masked row/column read mux.
// Revision: 1.0
// ============================================================================
module tile_bank
    import tile_transpose_pp_pkg::*;
#(
    parameter int T      = c_T_DEFAULT,
    parameter int DW     = c_DW_DEFAULT,
    parameter int LOG2_T = c_LOG2_T_DEFAULT
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [LOG2_T-1:0]   i_wrow,
    input  logic [T*DW-1:0]     i_wdat,
    input  logic                i_bypass,
    input  logic [LOG2_T-1:0]   i_idx,
    input  logic [LOG2_T:0]     i_rows,
    output logic [T*DW-1:0]     o_dat
);

    logic [T*DW-1:0] r_mem [T];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wrow] <= i_wdat;
        end
    end

    // Column read gathers lane i_idx of every stored row; rows past the tile end read as zero.
    always_comb begin
        o_dat = '0;
        if (i_bypass) begin
            o_dat = r_mem[i_idx];
        end else begin
            for (int i = 0; i < T; i++) begin
                if ((LOG2_T+1)'(i) < i_rows) begin
                    o_dat[lane_lsb(i, DW) +: DW] = r_mem[i][lane_lsb(int'(i_idx), DW) +: DW];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tile_transpose_pp.sv
`default_nettype none
// ============================================================================
// Module  : tile_transpose_pp
// Brief   : Ping-pong T x T tile transposer with bypass, partial tiles, soft clear.
// Revision: 1.0
// ============================================================================
module tile_transpose_pp
    import tile_transpose_pp_pkg::*;
#(
    parameter int T      = c_T_DEFAULT,
    parameter int DW     = c_DW_DEFAULT,
    parameter int LOG2_T = c_LOG2_T_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sw_clr,
    input  logic [LOG2_T:0]     cfg_rows,
    input  logic                cfg_bypass,
    input  logic                in_vld,
    output logic                in_rdy,
    input  logic [T*DW-1:0]     in_dat,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic [T*DW-1:0]     out_dat,
    output logic                out_last,
    output logic                tile_done,
    output logic                busy
);

    localparam logic [LOG2_T:0] c_T_CNT = (LOG2_T+1)'(T);

    logic [1:0]         r_full;
    logic [LOG2_T:0]    r_rows [2];
    mode_e              r_mode [2];
    logic               r_wb;
    logic               r_rb;
    logic [LOG2_T:0]    r_wr_row;
    logic [LOG2_T:0]    r_rd_cnt;
    logic               r_tile_done;

    logic [LOG2_T:0]    w_cfg_rows;
    logic [LOG2_T:0]    w_wr_rows;
    logic [LOG2_T:0]    w_rd_beats;
    logic               w_in_acc;
    logic               w_wr_done;
    logic               w_out_acc;
    logic               w_rd_end;
    logic               w_rd_done;
    logic [T*DW-1:0]    w_bank_dat [2];

    assign w_cfg_rows = (cfg_rows == '0) ? c_T_CNT : cfg_rows;
    // The first row of a tile has not latched its row count yet, so use the live config.
    assign w_wr_rows  = (r_wr_row == '0) ? w_cfg_rows : r_rows[r_wb];
    assign in_rdy     = ~r_full[r_wb];
    assign w_in_acc   = in_vld & in_rdy;
    assign w_wr_done  = w_in_acc & (r_wr_row == (w_wr_rows - 1'b1));

    assign w_rd_beats = (r_mode[r_rb] == MODE_BYPASS) ? r_rows[r_rb] : c_T_CNT;
    assign out_vld    = r_full[r_rb];
    assign w_rd_end   = (r_rd_cnt == (w_rd_beats - 1'b1));
    assign out_last   = out_vld & w_rd_end;
    assign w_out_acc  = out_vld & out_rdy;
    assign w_rd_done  = w_out_acc & w_rd_end;

    assign out_dat    = w_bank_dat[r_rb];
    assign tile_done  = r_tile_done;
    assign busy       = (|r_full) | (r_wr_row != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full      <= '0;
            r_rows      <= '{default: '0};
            r_mode      <= '{default: MODE_TRANSPOSE};
            r_wb        <= 1'b0;
            r_rb        <= 1'b0;
            r_wr_row    <= '0;
            r_rd_cnt    <= '0;
            r_tile_done <= 1'b0;
        end else if (sw_clr) begin
            r_full      <= '0;
            r_rows      <= '{default: '0};
            r_mode      <= '{default: MODE_TRANSPOSE};
            r_wb        <= 1'b0;
            r_rb        <= 1'b0;
            r_wr_row    <= '0;
            r_rd_cnt    <= '0;
            r_tile_done <= 1'b0;
        end else begin
            r_tile_done <= w_rd_done;
            if (w_in_acc) begin
                if (r_wr_row == '0) begin
                    r_rows[r_wb] <= w_cfg_rows;
                    r_mode[r_wb] <= mode_e'(cfg_bypass);
                end
                if (w_wr_done) begin
                    r_full[r_wb] <= 1'b1;
                    r_wb         <= ~r_wb;
                    r_wr_row     <= '0;
                end else begin
                    r_wr_row     <= r_wr_row + 1'b1;
                end
            end
            if (w_out_acc) begin
                if (w_rd_end) begin
                    r_full[r_rb] <= 1'b0;
                    r_rb         <= ~r_rb;
                    r_rd_cnt     <= '0;
                end else begin
                    r_rd_cnt     <= r_rd_cnt + 1'b1;
                end
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        tile_bank #(
            .T      (T),
            .DW     (DW),
            .LOG2_T (LOG2_T)
        ) u_bank (
            .clk      (clk),
            .i_we     (w_in_acc & (r_wb == 1'(b))),
            .i_wrow   (r_wr_row[LOG2_T-1:0]),
            .i_wdat   (in_dat),
            .i_bypass (r_mode[b] == MODE_BYPASS),
            .i_idx    (r_rd_cnt[LOG2_T-1:0]),
            .i_rows   (r_rows[b]),
            .o_dat    (w_bank_dat[b])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_transpose_pp.sv
`default_nettype none
// ============================================================================
// Module  : tb_tile_transpose_pp
// Brief   : Directed and randomised bench for tile_transpose_pp at T=4, DW=8.
// Revision: 1.0
// ============================================================================
module tb_tile_transpose_pp;

    localparam int T      = 4;
    localparam int DW     = 8;
    localparam int LOG2_T = 2;
    localparam int W      = T * DW;

    typedef struct packed {
        logic [W-1:0]    dat;
        logic [LOG2_T:0] rows;
        logic            byp;
    } in_t;

    typedef struct packed {
        logic [W-1:0] dat;
        logic         last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            sw_clr;
    logic [LOG2_T:0] cfg_rows;
    logic            cfg_bypass;
    logic            in_vld;
    logic            in_rdy;
    logic [W-1:0]    in_dat;
    logic            out_vld;
    logic            out_rdy;
    logic [W-1:0]    out_dat;
    logic            out_last;
    logic            tile_done;
    logic            busy;

    int   total = 0;
    int   bad   = 0;
    in_t  in_q[$];
    exp_t exp_q[$];
    bit   exp_done = 1'b0;
    int   cyc = 0;
    int   in_acc_cnt;
    int   out_acc_cnt;
    int   first_out;
    int   last_out;

    tile_transpose_pp #(.T(T), .DW(DW), .LOG2_T(LOG2_T)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_clr     (sw_clr),
        .cfg_rows   (cfg_rows),
        .cfg_bypass (cfg_bypass),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_dat     (in_dat),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_dat    (out_dat),
        .out_last   (out_last),
        .tile_done  (tile_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue one tile of stimulus and its expected output beats.
    task automatic add_tile(input int nr_cfg, input bit byp, input bit rnd);
        logic [W-1:0] rows [T];
        logic [W-1:0] d;
        int n;
        n = (nr_cfg == 0) ? T : nr_cfg;
        for (int r = 0; r < n; r++) begin
            for (int i = 0; i < T; i++)
                rows[r][i*DW +: DW] = rnd ? 8'($urandom) : 8'(r * 16 + i);
            in_q.push_back('{dat: rows[r], rows: (LOG2_T+1)'(nr_cfg), byp: byp});
        end
        if (byp) begin
            for (int r = 0; r < n; r++) exp_q.push_back('{dat: rows[r], last: (r == n - 1)});
        end else begin
            for (int c = 0; c < T; c++) begin
                d = '0;
                for (int i = 0; i < n; i++) d[i*DW +: DW] = rows[i][c*DW +: DW];
                exp_q.push_back('{dat: d, last: (c == T - 1)});
            end
        end
    endtask

    // One iteration per clock: drive after the edge, sample, then score accepted beats.
    task automatic run(input int max_cyc, input int vp, input int rp, input bit until_empty);
        int it;
        bit ia, oa;
        it = 0;
        while (it < max_cyc && (!until_empty || in_q.size() > 0 || exp_q.size() > 0 || exp_done)) begin
            @(posedge clk);
            #1;
            cyc++;
            in_vld  = (in_q.size() > 0) && ($urandom_range(0, 99) < vp);
            in_dat  = (in_q.size() > 0) ? in_q[0].dat  : '0;
            cfg_rows   = (in_q.size() > 0) ? in_q[0].rows : '0;
            cfg_bypass = (in_q.size() > 0) ? in_q[0].byp  : 1'b0;
            out_rdy = ($urandom_range(0, 99) < rp);
            #1;
            chk("tile_done", tile_done, exp_done);
            exp_done = 1'b0;
            ia = in_vld & in_rdy;
            oa = out_vld & out_rdy;
            if (ia) begin
                void'(in_q.pop_front());
                in_acc_cnt++;
            end
            if (oa) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", out_vld, 0);
                end else begin
                    chk("out_dat", out_dat, exp_q[0].dat);
                    chk("out_last", out_last, exp_q[0].last);
                    exp_done = exp_q[0].last;
                    void'(exp_q.pop_front());
                end
                if (out_acc_cnt == 0) first_out = cyc;
                last_out = cyc;
                out_acc_cnt++;
            end
            it++;
        end
        if (until_empty) chk("timeout_left", exp_q.size() + in_q.size(), 0);
    endtask

    task automatic idle_inputs();
        in_vld = 1'b0;
        out_rdy = 1'b0;
        in_dat = '0;
        cfg_rows = '0;
        cfg_bypass = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sw_clr = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_out_vld", out_vld, 0);
        rst = 1'b0;
        #1;
        chk("rel_in_rdy", in_rdy, 1);
        chk("rel_out_vld", out_vld, 0);
        chk("rel_out_last", out_last, 0);
        chk("rel_tile_done", tile_done, 0);
        chk("rel_busy", busy, 0);

        // Full transpose tile: out_vld appears the cycle after the 4th accept.
        add_tile(4, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            run(1, 100, 0, 0);
            chk("first_vld_timing", out_vld, (k == 5));
        end
        chk("t1_beat0", out_dat, 32'h30201000);
        chk("t1_beat0_last", out_last, 0);
        run(100, 0, 100, 1);

        // Partial tile of two rows: lanes 2..3 are masked.
        add_tile(2, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) run(1, 100, 0, 0);
        chk("t2_beat0", out_dat, 32'h00001000);
        out_acc_cnt = 0;
        run(100, 0, 100, 1);
        chk("t2_beats", out_acc_cnt, 4);

        // Bypass tile of three rows.
        add_tile(3, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) run(1, 100, 0, 0);
        chk("t3_beat0", out_dat, 32'h03020100);
        out_acc_cnt = 0;
        run(100, 0, 100, 1);
        chk("t3_beats", out_acc_cnt, 3);

        // Back-pressure: three tiles, reader stalled.
        for (int k = 0; k < 3; k++) add_tile(4, 1'b0, 1'b1);
        in_acc_cnt = 0;
        run(12, 100, 0, 0);
        chk("bp_accepts", in_acc_cnt, 8);
        chk("bp_in_rdy_low", in_rdy, 0);
        for (int k = 1; k <= 5; k++) begin
            run(1, 0, 100, 0);
            chk("bp_in_rdy_release", in_rdy, (k == 5));
        end
        run(200, 100, 100, 1);

        // Sustained throughput with both sides always ready.
        for (int k = 0; k < 5; k++) add_tile(4, 1'b0, 1'b1);
        out_acc_cnt = 0;
        run(200, 100, 100, 1);
        chk("thru_beats", out_acc_cnt, 20);
        chk("thru_span", last_out - first_out + 1, 20);

        // Random handshakes over 100 mixed tiles.
        for (int k = 0; k < 100; k++) add_tile($urandom_range(0, T), 1'($urandom_range(0, 1)), 1'b1);
        run(20000, 60, 60, 1);

        // Soft clear with one full bank and a half-written tile.
        add_tile(4, 1'b0, 1'b1);
        run(4, 100, 0, 0);
        for (int r = 0; r < 2; r++) in_q.push_back('{dat: 32'hA5A5A5A5, rows: 3'd0, byp: 1'b0});
        run(2, 100, 0, 0);
        chk("clr_pre_busy", busy, 1);
        chk("clr_pre_out_vld", out_vld, 1);
        sw_clr = 1'b1;
        in_vld = 1'b1;
        in_dat = 32'h5A5A5A5A;
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        sw_clr = 1'b0;
        idle_inputs();
        #1;
        chk("clr_out_vld", out_vld, 0);
        chk("clr_in_rdy", in_rdy, 1);
        chk("clr_busy", busy, 0);
        chk("clr_tile_done", tile_done, 0);
        in_q.delete();
        exp_q.delete();
        exp_done = 1'b0;
        add_tile(4, 1'b0, 1'b0);
        run(100, 100, 100, 1);

        // Asynchronous reset in the middle of a cycle, same scenario.
        add_tile(4, 1'b0, 1'b1);
        run(4, 100, 0, 0);
        for (int r = 0; r < 2; r++) in_q.push_back('{dat: 32'h11223344, rows: 3'd0, byp: 1'b0});
        run(2, 100, 0, 0);
        chk("rst_pre_busy", busy, 1);
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_vld", out_vld, 0);
        chk("arst_in_rdy", in_rdy, 1);
        chk("arst_busy", busy, 0);
        chk("arst_out_last", out_last, 0);
        chk("arst_tile_done", tile_done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_q.delete();
        exp_q.delete();
        exp_done = 1'b0;
        add_tile(4, 1'b0, 1'b0);
        run(100, 100, 100, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
